// File: rtl/pwm_multi_ch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pwm_multi_ch
// Brief    : Multi-channel PWM generator sharing one period counter. Each
//            channel has a shadow duty register that is written by the host
//            and an active duty register loaded at reload events, so duty and
//            period updates never glitch a running period.
//            Optional macro PWM_CENTER_ALIGN_EN adds input center_mode and
//            an up/down counting mode. Without the macro, only edge-aligned
//            counting is built.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pwm_multi_ch #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic                                             en,
`ifdef PWM_CENTER_ALIGN_EN
   input  logic                                             center_mode,
`endif
   input  logic [CNT_WIDTH-1:0]                             period,
   input  logic                                             duty_wr,
   input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0]   duty_ch,
   input  logic [CNT_WIDTH-1:0]                             duty_val,
   output logic [CHANNELS-1:0]                              pwm_out,
   output logic                                             period_end
);

   localparam int CH_W = $clog2(CHANNELS > 1 ? CHANNELS : 2);

   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] period_act;
   logic                 reload;

`ifdef PWM_CENTER_ALIGN_EN
   logic                 mode_act;   // center mode latched at reload
   logic                 dir_down;   // 1 while counting down in center mode

   // Center mode: cnt returns to 0 only at the start of a period, so cnt==0
   // marks both the first start and the end of each down-count.
   assign reload = mode_act ? (cnt == '0) : (cnt == period_act);
`else
   assign reload = (cnt == period_act);
`endif

   // Shared period counter, active period register and reload pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         period_act <= '0;
         period_end <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         mode_act   <= 1'b0;
         dir_down   <= 1'b0;
`endif
      end else if (!en) begin
         // Parked: keep the active settings tracking the inputs so that a
         // re-enable starts a fresh period with current values.
         cnt        <= '0;
         period_act <= period;
         period_end <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         mode_act   <= center_mode;
         dir_down   <= 1'b0;
`endif
      end else begin
         period_end <= reload;
         if (reload) begin
            period_act <= period;
`ifdef PWM_CENTER_ALIGN_EN
            mode_act   <= center_mode;
            dir_down   <= 1'b0;
            // A center reload happens on the cnt=0 cycle, which is already
            // the first cycle of the new period, so counting resumes at 1.
            if (mode_act && (period != '0)) begin
               cnt <= CNT_WIDTH'(1);
            end else begin
               cnt <= '0;
            end
`else
            cnt        <= '0;
`endif
         end else begin
`ifdef PWM_CENTER_ALIGN_EN
            if (mode_act) begin
               if (dir_down) begin
                  cnt <= cnt - CNT_WIDTH'(1);
               end else if (cnt == period_act) begin
                  dir_down <= 1'b1;
                  cnt      <= cnt - CNT_WIDTH'(1);
               end else begin
                  cnt <= cnt + CNT_WIDTH'(1);
               end
            end else begin
               cnt <= cnt + CNT_WIDTH'(1);
            end
`else
            cnt <= cnt + CNT_WIDTH'(1);
`endif
         end
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CNT_WIDTH-1:0] shadow;
      logic [CNT_WIDTH-1:0] active;
      logic                 pwm_q;

      // Per-channel shadow write, active load at reload/park, output compare
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            pwm_q  <= 1'b0;
         end else begin
            if (duty_wr && (duty_ch == CH_W'(i))) begin
               shadow <= duty_val;
            end
            // Uses the shadow value from before this edge, so a write on the
            // reload cycle waits for the following reload.
            if (!en || reload) begin
               active <= shadow;
            end
            pwm_q <= en && (cnt < active);
         end
      end

      assign pwm_out[i] = pwm_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pwm_multi_ch
// Brief    : Self-checking bench for pwm_multi_ch (edge mode, 4 channels,
//            8-bit counter). A reference model queues the expected outputs
//            for every clock; scenario tasks add directed checks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pwm_multi_ch;

   localparam int CHANNELS  = 4;
   localparam int CNT_WIDTH = 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 en;
   logic [CNT_WIDTH-1:0] period;
   logic                 duty_wr;
   logic [1:0]           duty_ch;
   logic [CNT_WIDTH-1:0] duty_val;
   logic [CHANNELS-1:0]  pwm_out;
   logic                 period_end;

   pwm_multi_ch #(
      .CHANNELS  (CHANNELS),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .period     (period),
      .duty_wr    (duty_wr),
      .duty_ch    (duty_ch),
      .duty_val   (duty_val),
      .pwm_out    (pwm_out),
      .period_end (period_end)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CHANNELS-1:0] pwm;
      logic                pe;
   } exp_t;

   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   string phase  = "init";

   // Reference model state
   int m_cnt;
   int m_pact;
   int m_sh  [CHANNELS];
   int m_act [CHANNELS];

   // Counters filled by run_count
   int ones [CHANNELS];
   int pes;

   task automatic model_reset();
      m_cnt  = 0;
      m_pact = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         m_sh[i]  = 0;
         m_act[i] = 0;
      end
   endtask

   // Advance the model across one rising edge using the current inputs
   task automatic model_edge();
      if (!en) begin
         m_cnt  = 0;
         m_pact = int'(period);
         for (int i = 0; i < CHANNELS; i++) m_act[i] = m_sh[i];
      end else if (m_cnt == m_pact) begin
         m_cnt  = 0;
         m_pact = int'(period);
         for (int i = 0; i < CHANNELS; i++) m_act[i] = m_sh[i];
      end else begin
         m_cnt = m_cnt + 1;
      end
      if (duty_wr) m_sh[duty_ch] = int'(duty_val);
   endtask

   // One clock: queue the expectation, clock the DUT, compare
   task automatic step();
      exp_t e;
      exp_t got;
      for (int i = 0; i < CHANNELS; i++) e.pwm[i] = en && (m_cnt < m_act[i]);
      e.pe = en && (m_cnt == m_pact);
      exp_q.push_back(e);
      model_edge();
      @(posedge clk);
      #2;
      got = exp_q.pop_front();
      checks++;
      if (pwm_out !== got.pwm) begin
         errors++;
         $display("FAIL %s pwm_out got=%b exp=%b t=%0t", phase, pwm_out, got.pwm, $time);
      end
      checks++;
      if (period_end !== got.pe) begin
         errors++;
         $display("FAIL %s period_end got=%b exp=%b t=%0t", phase, period_end, got.pe, $time);
      end
   endtask

   task automatic write_duty(input int ch, input int val);
      duty_wr  = 1'b1;
      duty_ch  = ch[1:0];
      duty_val = val[7:0];
      step();
      duty_wr  = 1'b0;
   endtask

   task automatic run_count(input int n);
      for (int i = 0; i < CHANNELS; i++) ones[i] = 0;
      pes = 0;
      for (int k = 0; k < n; k++) begin
         step();
         for (int i = 0; i < CHANNELS; i++) ones[i] += int'(pwm_out[i]);
         pes += int'(period_end);
      end
   endtask

   task automatic wait_pe(input int bound);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (period_end !== 1'b1 && k < bound);
      checks++;
      if (period_end !== 1'b1) begin
         errors++;
         $display("FAIL %s wait_pe timeout got=%b exp=1", phase, period_end);
      end
   endtask

   task automatic wait_cnt(input int target, input int bound);
      int k;
      k = 0;
      while (m_cnt != target && k < bound) begin
         step();
         k++;
      end
      checks++;
      if (m_cnt != target) begin
         errors++;
         $display("FAIL %s wait_cnt timeout got=%0d exp=%0d", phase, m_cnt, target);
      end
   endtask

   task automatic test_reset();
      phase = "reset";
      rst_n = 1'b0; en = 1'b0; period = '0;
      duty_wr = 1'b0; duty_ch = '0; duty_val = '0;
      model_reset();
      #3;
      checks++;
      if (pwm_out !== 4'b0000) begin
         errors++; $display("FAIL reset pwm_out got=%b exp=0000", pwm_out);
      end
      checks++;
      if (period_end !== 1'b0) begin
         errors++; $display("FAIL reset period_end got=%b exp=0", period_end);
      end
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      step();
      step();
   endtask

   task automatic test_basic();
      phase  = "basic";
      period = 8'd9;
      write_duty(0, 3);
      step();
      en = 1'b1;
      wait_pe(30);
      run_count(10);
      checks++;
      if (ones[0] != 3) begin
         errors++; $display("FAIL basic ch0 high cycles got=%0d exp=3", ones[0]);
      end
      checks++;
      if (pes != 1) begin
         errors++; $display("FAIL basic period_end count got=%0d exp=1", pes);
      end
   endtask

   task automatic test_boundary();
      phase = "boundary";
      write_duty(1, 0);
      write_duty(2, 10);
      write_duty(3, 255);
      wait_pe(30);
      run_count(20);
      checks++;
      if (ones[1] != 0) begin
         errors++; $display("FAIL boundary ch1 highs got=%0d exp=0", ones[1]);
      end
      checks++;
      if (ones[2] != 20 || ones[3] != 20) begin
         errors++; $display("FAIL boundary ch2/ch3 highs got=%0d/%0d exp=20/20", ones[2], ones[3]);
      end
      checks++;
      if (ones[0] != 6 || pes != 2) begin
         errors++; $display("FAIL boundary ch0/pe got=%0d/%0d exp=6/2", ones[0], pes);
      end
   endtask

   task automatic test_update();
      phase = "update";
      wait_cnt(5, 20);
      write_duty(0, 7);
      wait_pe(20);
      run_count(10);
      checks++;
      if (ones[0] != 7) begin
         errors++; $display("FAIL update new duty highs got=%0d exp=7", ones[0]);
      end
      wait_cnt(9, 20);
      write_duty(0, 2);   // lands on the reload cycle
      checks++;
      if (period_end !== 1'b1) begin
         errors++; $display("FAIL update reload-cycle write pe got=%b exp=1", period_end);
      end
      run_count(10);
      checks++;
      if (ones[0] != 7) begin
         errors++; $display("FAIL update reload-write held highs got=%0d exp=7", ones[0]);
      end
      run_count(10);
      checks++;
      if (ones[0] != 2) begin
         errors++; $display("FAIL update reload-write applied highs got=%0d exp=2", ones[0]);
      end
   endtask

   task automatic test_enable();
      logic [9:0] seq;
      logic [9:0] want;
      phase = "enable";
      repeat (3) step();
      period = 8'd4;
      write_duty(0, 2);
      en = 1'b0;
      step();
      checks++;
      if (pwm_out !== 4'b0000 || period_end !== 1'b0) begin
         errors++; $display("FAIL enable off outputs got=%b/%b exp=0000/0", pwm_out, period_end);
      end
      step();
      step();
      en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         seq[k]  = pwm_out[0];
         want[k] = ((k % 5) < 2) ? 1'b1 : 1'b0;
      end
      checks++;
      if (seq !== want) begin
         errors++; $display("FAIL enable restart pattern got=%b exp=%b", seq, want);
      end
   endtask

   task automatic test_async_reset();
      phase  = "async_reset";
      period = 8'd9;
      write_duty(0, 5);
      en = 1'b0;
      step();
      en = 1'b1;
      wait_cnt(2, 20);
      checks++;
      if (pwm_out[0] !== 1'b1) begin
         errors++; $display("FAIL async_reset pre pwm0 got=%b exp=1", pwm_out[0]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (pwm_out !== 4'b0000 || period_end !== 1'b0) begin
         errors++; $display("FAIL async_reset outputs got=%b/%b exp=0000/0", pwm_out, period_end);
      end
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      // Cleared period_act makes the first enabled edge a reload with zero duty
      step();
      checks++;
      if (pwm_out !== 4'b0000 || period_end !== 1'b1) begin
         errors++; $display("FAIL async_reset first edge got=%b/%b exp=0000/1", pwm_out, period_end);
      end
      repeat (12) step();
   endtask

   task automatic test_period_zero();
      phase  = "period_zero";
      period = 8'd0;
      write_duty(1, 1);
      write_duty(2, 10);
      en = 1'b0;
      step();
      en = 1'b1;
      run_count(8);
      checks++;
      if (pes != 8) begin
         errors++; $display("FAIL period_zero pe count got=%0d exp=8", pes);
      end
      checks++;
      if (ones[0] != 0 || ones[1] != 8 || ones[2] != 8) begin
         errors++; $display("FAIL period_zero highs got=%0d/%0d/%0d exp=0/8/8", ones[0], ones[1], ones[2]);
      end
   endtask

   task automatic test_back_to_back();
      phase  = "back_to_back";
      period = 8'd6;
      write_duty(0, 1);
      write_duty(1, 2);
      write_duty(2, 3);
      write_duty(3, 7);
      wait_pe(20);
      run_count(7);
      checks++;
      if (ones[0] != 1 || ones[1] != 2 || ones[2] != 3 || ones[3] != 7) begin
         errors++; $display("FAIL back_to_back highs got=%0d/%0d/%0d/%0d exp=1/2/3/7", ones[0], ones[1], ones[2], ones[3]);
      end
   endtask

   task automatic test_random();
      phase = "random";
      for (int k = 0; k < 400; k++) begin
         en      = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 29) == 0) period = 8'($urandom_range(0, 12));
         duty_wr  = ($urandom_range(0, 3) == 0);
         duty_ch  = 2'($urandom_range(0, 3));
         duty_val = 8'($urandom_range(0, 15));
         step();
      end
      duty_wr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_update();
      test_enable();
      test_async_reset();
      test_period_zero();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pwm_multi_ch.md
PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent PWM channels (1..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the period counter, period value and duty values (2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  run enable; 0 = counter parked, outputs low.
REQ-006 SHALL have port period  input  CNT_WIDTH  period value P; the edge-aligned period is P+1 cycles.
REQ-007 SHALL have port duty_wr  input  1  one-cycle write strobe for a duty shadow register.
REQ-008 SHALL have port duty_ch  input  max(1,$clog2(CHANNELS))  channel index for duty_wr.
REQ-009 SHALL have port duty_val  input  CNT_WIDTH  duty value D written to shadow[duty_ch].
REQ-010 SHALL have port pwm_out  output  CHANNELS  registered PWM outputs.
REQ-011 SHALL have port period_end  output  1  registered one-cycle pulse marking each reload event.

Function
REQ-012 SHALL hold per channel one shadow duty register and one active duty register, plus a shadow-free active period register period_act and counter cnt.
REQ-013 duty_wr=1 SHALL update shadow[duty_ch] at that edge; duty_ch >= CHANNELS SHALL be ignored.
REQ-014 Edge mode, en=1: if cnt==period_act then cnt<=0 (reload event), else cnt<=cnt+1.
REQ-015 On a reload event, period_act<=period and every active duty<=its shadow at that same edge.
REQ-016 A duty write on the reload-event cycle SHALL NOT bypass into active; it takes effect at the following reload event.
REQ-017 pwm_out[i] at cycle t+1 SHALL equal en(t) & (cnt(t) < duty_act[i](t)); fixed one-cycle latency.
REQ-018 period_end at cycle t+1 SHALL equal en(t) & reload event at t.
REQ-019 D=0 SHALL give constant low; D>=P+1 SHALL give constant high (100%); no glitch at wrap.
REQ-020 P=0 SHALL reload every cycle; output high iff D>0; period_end constantly high while en=1.
REQ-021 en=0 SHALL force cnt<=0, direction<=up, pwm_out<=0, period_end<=0, and copy period/shadows into active registers every cycle, so re-enable starts a fresh period at cnt=0 with current settings.
REQ-022 Counter arithmetic SHALL be unsigned CNT_WIDTH with no overflow possible (cnt never exceeds period_act).

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) clear cnt, period_act, all shadow and active duty registers, direction flag, pwm_out and period_end to 0.
REQ-024 After rst_n release, first edge SHALL behave as en-governed operation from cnt=0; reset mid-period SHALL abandon the period with no residual pulse.

Configuration
REQ-025 Macro PWM_CENTER_ALIGN_EN defined SHALL add port center_mode input 1 (0 = edge mode, 1 = center mode); undefined SHALL omit the port and direction flag, edge mode only.
REQ-026 Center mode: cnt counts up 0..P then down P-1..0 (period 2P cycles, P>0); reload event is the cycle where cnt==0 and counting down or at first start; output rule of REQ-017 unchanged (symmetric pulse of 2D-1 cycles for 0<D<=P); P=0 behaves as REQ-020.
REQ-027 center_mode change SHALL take effect only at a reload event.

Verification
REQ-028 CHANNELS=4, CNT_WIDTH=8, P=9, shadow0=3, en=1 -> after first period_end, pwm_out[0] high 3 of every 10 cycles, period_end every 10 cycles.
REQ-029 shadow1=0, shadow2=10, shadow3=255 with P=9 -> pwm_out[1] constant 0, pwm_out[2] and pwm_out[3] constant 1.
REQ-030 P=9, D0=3, write D0=7 at cnt=5 -> current period keeps 3-cycle pulse, next period shows 7; write on reload cycle applies one period later.
REQ-031 rst_n pulsed low at cnt=2 with pwm_out[0]=1 -> pwm_out and period_end 0 before next edge, all registers 0.
REQ-032 en deasserted mid-period then reasserted with P=4, D0=2 -> outputs 0 one cycle after en=0; after re-enable pattern 1,1,0,0,0 repeats from cnt=0.
REQ-033 PWM_CENTER_ALIGN_EN, center_mode=1, P=4, D0=2 -> cnt sequence 0,1,2,3,4,3,2,1,0; pwm_out[0] high 3 cycles per 8-cycle period, centered on cnt=0.
